serv_timer: RTL and testbench
=============================

# serv_timer

Memory-mapped machine timer that generates the timer interrupt request consumed by the core's CSR stage as `i_mtip`. It holds a free-running `mtime` counter and an `mtimecmp` compare register, both on a Wishbone classic slave port. It drives a registered, level-sensitive `o_mtip` that stays high while the timer is expired and enabled. It sits on the peripheral bus next to the GPIO and RAM slaves, and its interrupt line is wired straight to the core.

## Interface
- `RESET_STRATEGY`, default "MINI". "MINI" resets every register. "NONE" leaves `mtime` and `mtimecmp` unreset; `ctrl`, `o_wb_ack` and `o_mtip` are always reset.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset: synchronous, active-high. The clock is `i_clk`.
- `i_wb_adr`  in  2  word address; only the low 2 bits of the byte address [3:2] are decoded.
- `i_wb_dat`  in  32  write data.
- `i_wb_sel`  in  4  byte enables.
- `i_wb_we`  in  1  write strobe qualifier.
- `i_wb_cyc`  in  1  bus cycle.
- `i_wb_stb`  in  1  strobe.
- `o_wb_rdt`  out  32  read data; valid while `o_wb_ack` is high.
- `o_wb_ack`  out  1  single-cycle acknowledge.
- `o_mtip`  out  1  timer interrupt pending, to the core's `i_mtip`.

## Operation
Register map (word index):
- 0 `mtime`, R/W, 32 bits.
- 1 `mtimecmp`, R/W, 32 bits.
- 2 `ctrl`, R/W:
  - bit0 EN: count enable.
  - bit1 IEN: interrupt enable.
  - other bits read as 0.
- 3 `presc`: see Configuration.

Counting and interrupt:
- `mtime` increments by 1 on each tick while EN=1. It wraps from 0xFFFFFFFF to 0.
- Expiry is wrap-safe: `expired` = bit 31 of (`mtime` − `mtimecmp`) is 0, i.e. the signed difference is ≥ 0.
- `o_mtip` is registered: next value = IEN & `expired`. It stays high until software moves `mtimecmp` ahead or clears IEN.

Writes:
- Writes are byte-granular per `i_wb_sel`. Unselected bytes keep their value.
- A software write to `mtime` in the same cycle as a tick wins; there is no increment that cycle.

Reads:
- Reads return the register value sampled in the request cycle.

Reset values:
- `o_wb_ack`=0, `o_mtip`=0, `ctrl`=0, `o_wb_rdt`=0.
- With "MINI" also `mtime`=0 and `mtimecmp`=0xFFFFFFFF.

## Timing
- A request is `i_wb_cyc & i_wb_stb & !o_wb_ack`.
- `o_wb_ack` rises exactly 1 cycle after the request and lasts 1 cycle. Back-to-back requests therefore complete every 2 cycles.
- A write takes effect on the same edge that raises `o_wb_ack`.
- `o_mtip` latency: 1 cycle after the edge where `mtime`, `mtimecmp` or IEN changes. Example: a write of `mtimecmp` ≤ `mtime` acked at edge N gives `o_mtip`=1 after edge N+1.
- Reset mid-transaction: ack is dropped and the write is discarded if reset is asserted in the request cycle. The master must reissue the request.
- `i_wb_cyc` deasserted before ack: the transaction is abandoned. The ack still pulses once and is ignored by the master.

## Configuration
- `SERV_TIMER_PRESCALER_EN` defined:
  - `presc` (index 3) is an 8-bit R/W register, reset 0.
  - An internal 8-bit counter generates a tick when it equals `presc`, then clears. `presc`=0 gives a tick every cycle.
  - The counter clears when EN=0 and when `presc` is written.
- Macro undefined:
  - Tick = EN every cycle.
  - Index 3 reads 0; writes to it are ignored.

## Structure
- A shared package `serv_timer_pkg` holds:
  - register index constants `TIMER_MTIME`, `TIMER_MTIMECMP`, `TIMER_CTRL`, `TIMER_PRESC`;
  - `ctrl` bit positions;
  - the `mtimecmp` reset constant.
- One natural sub-module, `serv_timer_prescaler`, contains the tick generator. It is instantiated only when the macro is defined.

## Test plan
- **Reset:** after reset, `o_mtip`=0, a read of `ctrl` returns 0, a read of `mtimecmp` returns 0xFFFFFFFF, and `o_wb_ack` is 1 cycle after the request.
- **Basic expiry:**
  - Write `mtimecmp`=20, then `ctrl`=3.
  - `o_mtip` rises 1 cycle after `mtime` reaches 20.
  - Writing `mtimecmp`=1000 drops `o_mtip` within 2 cycles.
- **Wrap:**
  - Write `mtime`=0xFFFFFFF0 and `mtimecmp`=0x00000010, with EN and IEN set.
  - `o_mtip` stays 0 until `mtime` wraps and reaches 0x10. It must not be high at 0xFFFFFFF0.
- **Collision and byte enables:**
  - A write of `mtime`=0x12345678 with `sel`=0b0011 while counting reads back 0x????5678 with the upper half unchanged.
  - No increment occurs in the write cycle.
- **Prescaler** (macro on): `presc`=3 gives `mtime` +1 every 4 cycles. Macro off: `presc` reads 0 after a write of 0xFF.
- **IEN gating:** with `mtime` > `mtimecmp` and IEN=0, `o_mtip` stays 0. Setting IEN raises it 1 cycle after the ack edge.

Source files
------------

// File: rtl/serv_timer_pkg.sv
// Shared definitions for the machine timer: register indices, ctrl bit positions,
// reset constants and the wrap-safe expiry test.
package serv_timer_pkg;

   localparam logic [1:0] TIMER_MTIME    = 2'd0;
   localparam logic [1:0] TIMER_MTIMECMP = 2'd1;
   localparam logic [1:0] TIMER_CTRL     = 2'd2;
   localparam logic [1:0] TIMER_PRESC    = 2'd3;

   localparam int CTRL_EN  = 0;
   localparam int CTRL_IEN = 1;

   localparam logic [31:0] MTIMECMP_RESET = 32'hFFFF_FFFF;

   // Expired when the signed distance mtime - mtimecmp is non-negative, so the
   // comparison keeps working across the 32-bit wrap.
   function automatic logic timer_expired(input logic [31:0] mtime, input logic [31:0] mtimecmp);
      logic [31:0] diff;
      diff = mtime - mtimecmp;
      return ~diff[31];
   endfunction

endpackage

// File: rtl/serv_timer_if.sv
// Wishbone classic bus bundle for the timer slave.
interface serv_timer_if;
   logic [1:0]  adr;
   logic [31:0] dat;
   logic [3:0]  sel;
   logic        we;
   logic        cyc;
   logic        stb;
   logic [31:0] rdt;
   logic        ack;

   modport master (output adr, dat, sel, we, cyc, stb, input rdt, ack);
   modport slave  (input adr, dat, sel, we, cyc, stb, output rdt, ack);
endinterface

// File: rtl/serv_timer_prescaler.sv
// Tick generator: one tick every presc+1 enabled cycles; restarts on disable or
// whenever the divider value is rewritten.
module serv_timer_prescaler (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       en,
   input  logic       clr,
   input  logic [7:0] presc,
   output logic       tick
);

   logic [7:0] cnt_reg;

   assign tick = en & (cnt_reg == presc);

   always_ff @(posedge i_clk) begin
      if (i_rst || !en || clr)
         cnt_reg <= '0;
      else if (cnt_reg == presc)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_reg + 8'd1;
   end

endmodule

// File: rtl/serv_timer.sv
// Memory-mapped machine timer (mtime/mtimecmp/ctrl/presc) driving the core's mtip.
// Optional divider at index 3 enabled by SERV_TIMER_PRESCALER_EN.
module serv_timer
   import serv_timer_pkg::*;
#(
   parameter RESET_STRATEGY = "MINI"
) (
   input  logic        i_clk,
   input  logic        i_rst,
   serv_timer_if.slave wb,
   output logic        o_mtip
);

   localparam bit RESET_ALL = (RESET_STRATEGY != "NONE");

   logic [31:0] mtime_reg;
   logic [31:0] mtimecmp_reg;
   logic [1:0]  ctrl_reg;
   logic        ack_reg;
   logic [31:0] rdt_reg;
   logic        mtip_reg;

   logic        req;
   logic        wr;
   logic        wr_mtime;
   logic        wr_mtimecmp;
   logic        wr_ctrl;
   logic        tick;
   logic [31:0] mtime_wdata;
   logic [31:0] mtimecmp_wdata;
   logic [31:0] rd_data;

   assign req         = wb.cyc & wb.stb & ~ack_reg;
   assign wr          = req & wb.we;
   assign wr_mtime    = wr & (wb.adr == TIMER_MTIME);
   assign wr_mtimecmp = wr & (wb.adr == TIMER_MTIMECMP);
   assign wr_ctrl     = wr & (wb.adr == TIMER_CTRL);

   // Byte lanes not selected keep their current contents.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign mtime_wdata[8*gi +: 8]    = wb.sel[gi] ? wb.dat[8*gi +: 8] : mtime_reg[8*gi +: 8];
         assign mtimecmp_wdata[8*gi +: 8] = wb.sel[gi] ? wb.dat[8*gi +: 8] : mtimecmp_reg[8*gi +: 8];
      end
   endgenerate

`ifdef SERV_TIMER_PRESCALER_EN
   logic [7:0] presc_reg;
   logic       wr_presc;

   assign wr_presc = wr & (wb.adr == TIMER_PRESC);

   always_ff @(posedge i_clk) begin
      if (i_rst)
         presc_reg <= '0;
      else if (wr_presc && wb.sel[0])
         presc_reg <= wb.dat[7:0];
   end

   serv_timer_prescaler u_prescaler (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .en    (ctrl_reg[CTRL_EN]),
      .clr   (wr_presc),
      .presc (presc_reg),
      .tick  (tick)
   );
`else
   assign tick = ctrl_reg[CTRL_EN];
`endif

   always_comb begin
      rd_data = '0;
      case (wb.adr)
         TIMER_MTIME:    rd_data = mtime_reg;
         TIMER_MTIMECMP: rd_data = mtimecmp_reg;
         TIMER_CTRL:     rd_data = {30'd0, ctrl_reg};
`ifdef SERV_TIMER_PRESCALER_EN
         TIMER_PRESC:    rd_data = {24'd0, presc_reg};
`endif
         default:        rd_data = '0;
      endcase
   end

   // A software write to mtime takes priority over the tick in the same cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         if (RESET_ALL) begin
            mtime_reg    <= '0;
            mtimecmp_reg <= MTIMECMP_RESET;
         end
      end else begin
         if (wr_mtime)
            mtime_reg <= mtime_wdata;
         else if (tick)
            mtime_reg <= mtime_reg + 32'd1;
         if (wr_mtimecmp)
            mtimecmp_reg <= mtimecmp_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ack_reg  <= 1'b0;
         rdt_reg  <= '0;
         ctrl_reg <= '0;
         mtip_reg <= 1'b0;
      end else begin
         ack_reg  <= req;
         rdt_reg  <= req ? rd_data : '0;
         if (wr_ctrl && wb.sel[0])
            ctrl_reg <= wb.dat[1:0];
         mtip_reg <= ctrl_reg[CTRL_IEN] & timer_expired(mtime_reg, mtimecmp_reg);
      end
   end

   assign wb.rdt = rdt_reg;
   assign wb.ack = ack_reg;
   assign o_mtip = mtip_reg;

endmodule

// File: tb/tb_serv_timer.sv
// Scoreboard bench for serv_timer: directed plan steps followed by random bus traffic,
// all checked against a cycle-level reference model of the timer rules.
module tb_serv_timer;
   import serv_timer_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mtip;

   serv_timer_if bus ();

   serv_timer dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .wb     (bus),
      .o_mtip (mtip)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_read;
      logic [1:0]  idx;
      logic [31:0] data;
   } exp_t;

   exp_t sb_q[$];

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_mtime = '0;
   logic [31:0] m_cmp   = 32'hFFFF_FFFF;
   logic [1:0]  m_ctrl  = '0;
   logic [7:0]  m_presc = '0;
   int          m_phase = 0;
   bit          m_ack   = 1'b0;
   bit          m_mtip  = 1'b0;
   bit          started = 1'b0;

   function automatic logic [31:0] model_read(input logic [1:0] idx);
      case (idx)
         2'd0: return m_mtime;
         2'd1: return m_cmp;
         2'd2: return {30'd0, m_ctrl};
`ifdef SERV_TIMER_PRESCALER_EN
         default: return {24'd0, m_presc};
`else
         default: return 32'd0;
`endif
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++)
         if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
      return r;
   endfunction

   // Model: evaluate every rule from the state seen at this edge, then commit.
   bit   req_m, wr_m, tick_m, en_m, mtip_n;
   exp_t e_m;
   always @(posedge clk) begin
      started = 1'b1;
      if (rst) begin
         m_mtime = '0; m_cmp = 32'hFFFF_FFFF; m_ctrl = '0; m_presc = '0;
         m_phase = 0; m_ack = 1'b0; m_mtip = 1'b0;
      end else begin
         req_m  = bus.cyc && bus.stb && !m_ack;
         wr_m   = req_m && bus.we;
         en_m   = m_ctrl[0];
         mtip_n = m_ctrl[1] && ($signed(m_mtime - m_cmp) >= 0);
         if (req_m) begin
            e_m.is_read = !bus.we;
            e_m.idx     = bus.adr;
            e_m.data    = model_read(bus.adr);
            sb_q.push_back(e_m);
         end
`ifdef SERV_TIMER_PRESCALER_EN
         tick_m = en_m && (m_phase == int'(m_presc));
         if (!en_m || (wr_m && bus.adr == 2'd3) || tick_m) m_phase = 0;
         else m_phase = m_phase + 1;
         if (wr_m && bus.adr == 2'd3 && bus.sel[0]) m_presc = bus.dat[7:0];
`else
         tick_m = en_m;
`endif
         if (wr_m && bus.adr == 2'd0) m_mtime = merge(m_mtime, bus.dat, bus.sel);
         else if (tick_m)             m_mtime = m_mtime + 32'd1;
         if (wr_m && bus.adr == 2'd1) m_cmp = merge(m_cmp, bus.dat, bus.sel);
         if (wr_m && bus.adr == 2'd2 && bus.sel[0]) m_ctrl = bus.dat[1:0];
         m_ack  = req_m;
         m_mtip = mtip_n;
      end
   end

   // Monitor: compare outputs mid-cycle and pop the scoreboard on each ack.
   exp_t e_c;
   always @(negedge clk) begin
      if (started) begin
         checks++;
         if (bus.ack !== m_ack) begin
            errors++;
            $display("FAIL ack t=%0t got=%b exp=%b", $time, bus.ack, m_ack);
         end
         checks++;
         if (mtip !== m_mtip) begin
            errors++;
            $display("FAIL mtip t=%0t got=%b exp=%b mtime=%h cmp=%h", $time, mtip, m_mtip, m_mtime, m_cmp);
         end
         if (bus.ack === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_ack t=%0t got=ack exp=no_pending_request", $time);
            end else begin
               e_c = sb_q.pop_front();
               if (e_c.is_read) begin
                  checks++;
                  if (bus.rdt !== e_c.data) begin
                     errors++;
                     $display("FAIL rdt idx=%0d t=%0t got=%h exp=%h", e_c.idx, $time, bus.rdt, e_c.data);
                  end else
                     $display("read  idx=%0d data=%h", e_c.idx, bus.rdt);
               end else
                  $display("write idx=%0d acked", e_c.idx);
            end
         end
      end
   end

   task automatic bus_op(input logic we, input logic [1:0] idx, input logic [31:0] d,
                         input logic [3:0] sel);
      @(negedge clk);
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.adr = idx; bus.dat = d; bus.sel = sel;
      @(negedge clk);
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
   endtask

   task automatic wr(input logic [1:0] idx, input logic [31:0] d);
      bus_op(1'b1, idx, d, 4'hF);
   endtask

   task automatic rd(input logic [1:0] idx);
      bus_op(1'b0, idx, 32'd0, 4'hF);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [31:0] rdat;
   initial begin
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
      bus.adr = '0; bus.dat = '0; bus.sel = '0;
      idle(3);
      rst = 1'b0;

      // Reset values
      rd(TIMER_CTRL); rd(TIMER_MTIMECMP); rd(TIMER_MTIME); rd(TIMER_PRESC);

      // Basic expiry then mtimecmp moved ahead
      wr(TIMER_MTIMECMP, 32'd20);
      wr(TIMER_CTRL, 32'd3);
      idle(30);
      wr(TIMER_MTIMECMP, 32'd1000);
      idle(4);

      // Wrap-around expiry
      wr(TIMER_CTRL, 32'd0);
      wr(TIMER_MTIME, 32'hFFFF_FFF0);
      wr(TIMER_MTIMECMP, 32'h0000_0010);
      wr(TIMER_CTRL, 32'd3);
      idle(40);

      // Partial-byte write colliding with a tick
      wr(TIMER_CTRL, 32'd1);
      bus_op(1'b1, TIMER_MTIME, 32'h1234_5678, 4'b0011);
      rd(TIMER_MTIME);

      // Divider
      wr(TIMER_PRESC, 32'hFF);
      rd(TIMER_PRESC);
      wr(TIMER_PRESC, 32'd3);
      wr(TIMER_MTIME, 32'd0);
      idle(15);
      rd(TIMER_MTIME);
      idle(2);
      rd(TIMER_MTIME);
      wr(TIMER_PRESC, 32'd0);

      // Interrupt enable gating
      wr(TIMER_CTRL, 32'd1);
      wr(TIMER_MTIMECMP, 32'd5);
      wr(TIMER_MTIME, 32'd100);
      idle(8);
      wr(TIMER_CTRL, 32'd3);
      idle(4);

      // Reset asserted in the request cycle discards the write
      @(negedge clk);
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = TIMER_MTIME;
      bus.dat = 32'h0000_0ABC; bus.sel = 4'hF; rst = 1'b1;
      @(negedge clk);
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; rst = 1'b0;
      rd(TIMER_MTIME); rd(TIMER_CTRL);

      // Random traffic
      wr(TIMER_CTRL, 32'd3);
      for (int i = 0; i < 300; i++) begin
         logic [1:0] idx;
         idx = 2'($urandom_range(0, 3));
         rdat = $urandom;
         if (idx == TIMER_MTIMECMP && $urandom_range(0, 1) == 1)
            rdat = m_mtime + 32'($urandom_range(0, 30)) - 32'd10;
         if (idx == TIMER_PRESC)
            rdat = 32'($urandom_range(0, 4));
         if (idx == TIMER_CTRL && $urandom_range(0, 3) != 0)
            rdat = 32'd3;
         bus_op(1'($urandom_range(0, 1)), idx, rdat, 4'($urandom_range(0, 15)));
         idle($urandom_range(0, 5));
      end
      idle(5);

      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL pending_acks got=%0d exp=0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
